// File: rtl/ddr3_pkg.sv
// -----------------------------------------------------------------------------
// ddr3_pkg
// Shared types and default widths for the DDR3 user-port arbitration slice.
//   DDR3_ADDR_W / DDR3_DATA_W : default word-address and data widths
//   arb_state_t               : arbiter grant state
//   ddr3_addr_t               : DDR3 word address at the default width
// -----------------------------------------------------------------------------
package ddr3_pkg;

  localparam int DDR3_ADDR_W = 25;
  localparam int DDR3_DATA_W = 256;

  typedef logic [DDR3_ADDR_W-1:0] ddr3_addr_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WR_GRANT = 2'd1,
    RD_GRANT = 2'd2
  } arb_state_t;

endpackage

// File: rtl/ddr3_rd_tracker.sv
// -----------------------------------------------------------------------------
// ddr3_rd_tracker
// Counts read commands accepted by DDR3 but not yet returned, flags when the
// count reaches its limit, records a sticky underflow error, and registers the
// DDR3 read return path toward the host.
// Ports:
//   sys_clk, sys_nrst      : clock, async active-low reset
//   cmd_ack                : read command accepted this cycle
//   ddr3_rd_data/_valid    : raw DDR3 read return
//   rd_data/rd_valid       : registered read return (1-cycle latency)
//   rd_outstanding         : reads in flight
//   rd_full                : rd_outstanding == RD_OUTSTANDING_MAX
//   err_underflow          : sticky, return seen with nothing in flight
// -----------------------------------------------------------------------------
module ddr3_rd_tracker
  import ddr3_pkg::*;
#(
  parameter int DATA_W             = DDR3_DATA_W,
  parameter int RD_OUTSTANDING_MAX = 4,
  parameter int CNT_W              = 3
) (
  input  logic              sys_clk,
  input  logic              sys_nrst,
  input  logic              cmd_ack,
  input  logic [DATA_W-1:0] ddr3_rd_data,
  input  logic              ddr3_rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic [CNT_W-1:0]  rd_outstanding,
  output logic              rd_full,
  output logic              err_underflow
);

  localparam logic [CNT_W-1:0] MAX_C  = CNT_W'(RD_OUTSTANDING_MAX);
  localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(32'd1);
  localparam logic [CNT_W-1:0] ZERO_C = CNT_W'(32'd0);

  // Full flag used by the arbiter to stop granting reads.
  always_comb begin
    if (rd_outstanding == MAX_C) begin
      rd_full = 1'b1;
    end else begin
      rd_full = 1'b0;
    end
  end

  // Outstanding counter and sticky underflow; simultaneous ack+return cancel.
  always_ff @(posedge sys_clk or negedge sys_nrst) begin
    if (!sys_nrst) begin
      rd_outstanding <= ZERO_C;
      err_underflow  <= 1'b0;
    end else begin
      case ({cmd_ack, ddr3_rd_valid})
        2'b10: begin
          // The arbiter never grants while full; saturate anyway.
          if (rd_outstanding != MAX_C) begin
            rd_outstanding <= rd_outstanding + ONE_C;
          end else begin
            rd_outstanding <= rd_outstanding;
          end
        end
        2'b01: begin
          if (rd_outstanding == ZERO_C) begin
            err_underflow <= 1'b1;
          end else begin
            rd_outstanding <= rd_outstanding - ONE_C;
          end
        end
        default: begin
          rd_outstanding <= rd_outstanding;
        end
      endcase
    end
  end

  // Return path register stage; no backpressure, order preserved.
  always_ff @(posedge sys_clk or negedge sys_nrst) begin
    if (!sys_nrst) begin
      rd_data  <= {DATA_W{1'b0}};
      rd_valid <= 1'b0;
    end else begin
      rd_data  <= ddr3_rd_data;
      rd_valid <= ddr3_rd_valid;
    end
  end

endmodule

// File: rtl/ddr3_rw_arbiter.sv
// -----------------------------------------------------------------------------
// ddr3_rw_arbiter
// Shares the DDR3 user command port between the frame writer (writes) and the
// readback engine (reads). One command is granted at a time with an IDLE
// cycle between commands; a pending read can be passed over by at most
// WR_BURST_MAX consecutive writes; reads stop being granted once
// RD_OUTSTANDING_MAX reads are in flight.
// Ports:
//   sys_clk, sys_nrst           : clock, async active-low reset
//   wr_req/wr_addr/wr_data      : write request (level, held until wr_ack)
//   wr_ack                      : write accepted (combinational)
//   rd_req/rd_addr              : read request (level, held until rd_ack)
//   rd_ack                      : read accepted (combinational)
//   rd_data/rd_valid            : registered read return
//   ddr3_wd_*                   : DDR3 write command handshake
//   ddr3_rd_req/_addr/_ack      : DDR3 read command handshake
//   ddr3_rd_data/_valid         : DDR3 read return
//   rd_outstanding              : reads in flight
//   err_underflow               : sticky return-with-nothing-in-flight error
// -----------------------------------------------------------------------------
module ddr3_rw_arbiter
  import ddr3_pkg::*;
#(
  parameter int ADDR_W             = DDR3_ADDR_W,
  parameter int DATA_W             = DDR3_DATA_W,
  parameter int WR_BURST_MAX       = 8,
  parameter int RD_OUTSTANDING_MAX = 4,
  parameter int CNT_W              = 3
) (
  input  logic              sys_clk,
  input  logic              sys_nrst,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ack,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              ddr3_wd_req,
  output logic [ADDR_W-1:0] ddr3_wd_addr,
  output logic [DATA_W-1:0] ddr3_wd_data,
  input  logic              ddr3_wd_ack,
  output logic              ddr3_rd_req,
  output logic [ADDR_W-1:0] ddr3_rd_addr,
  input  logic              ddr3_rd_ack,
  input  logic [DATA_W-1:0] ddr3_rd_data,
  input  logic              ddr3_rd_valid,
  output logic [CNT_W-1:0]  rd_outstanding,
  output logic              err_underflow
);

  localparam int                 BURST_W     = $clog2(WR_BURST_MAX + 1);
  localparam logic [BURST_W-1:0] BURST_MAX_C = BURST_W'(WR_BURST_MAX);
  localparam logic [BURST_W-1:0] BURST_ONE_C = BURST_W'(32'd1);

  arb_state_t         state_r;
  logic [BURST_W-1:0] burst_r;
  logic               rd_full_s;
  logic               rd_ok_s;

  // A read is eligible only while the in-flight window has room.
  always_comb begin
    if (rd_req && !rd_full_s) begin
      rd_ok_s = 1'b1;
    end else begin
      rd_ok_s = 1'b0;
    end
  end

  // Requester acks mirror the DDR3 ack, qualified by the active grant.
  always_comb begin
    if (state_r == WR_GRANT) begin
      wr_ack = ddr3_wd_ack;
    end else begin
      wr_ack = 1'b0;
    end
    if (state_r == RD_GRANT) begin
      rd_ack = ddr3_rd_ack;
    end else begin
      rd_ack = 1'b0;
    end
  end

  // Arbitration FSM with registered DDR3 command outputs.
  always_ff @(posedge sys_clk or negedge sys_nrst) begin
    if (!sys_nrst) begin
      state_r      <= IDLE;
      burst_r      <= {BURST_W{1'b0}};
      ddr3_wd_req  <= 1'b0;
      ddr3_wd_addr <= {ADDR_W{1'b0}};
      ddr3_wd_data <= {DATA_W{1'b0}};
      ddr3_rd_req  <= 1'b0;
      ddr3_rd_addr <= {ADDR_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          // Reads win when alone, or when writes have used up their burst.
          if (rd_ok_s && (!wr_req || (burst_r == BURST_MAX_C))) begin
            state_r      <= RD_GRANT;
            ddr3_rd_req  <= 1'b1;
            ddr3_rd_addr <= rd_addr;
          end else if (wr_req) begin
            state_r      <= WR_GRANT;
            ddr3_wd_req  <= 1'b1;
            ddr3_wd_addr <= wr_addr;
            ddr3_wd_data <= wr_data;
          end else begin
            state_r <= IDLE;
          end
        end
        WR_GRANT: begin
          if (ddr3_wd_ack) begin
            ddr3_wd_req <= 1'b0;
            state_r     <= IDLE;
            // Only writes that made a read wait count toward the burst.
            if (rd_req) begin
              if (burst_r != BURST_MAX_C) begin
                burst_r <= burst_r + BURST_ONE_C;
              end else begin
                burst_r <= burst_r;
              end
            end else begin
              burst_r <= {BURST_W{1'b0}};
            end
          end else begin
            state_r <= WR_GRANT;
          end
        end
        RD_GRANT: begin
          if (ddr3_rd_ack) begin
            ddr3_rd_req <= 1'b0;
            state_r     <= IDLE;
            burst_r     <= {BURST_W{1'b0}};
          end else begin
            state_r <= RD_GRANT;
          end
        end
        default: begin
          state_r     <= IDLE;
          ddr3_wd_req <= 1'b0;
          ddr3_rd_req <= 1'b0;
        end
      endcase
    end
  end

  ddr3_rd_tracker #(
    .DATA_W            (DATA_W),
    .RD_OUTSTANDING_MAX(RD_OUTSTANDING_MAX),
    .CNT_W             (CNT_W)
  ) u_rd_tracker (
    .sys_clk       (sys_clk),
    .sys_nrst      (sys_nrst),
    .cmd_ack       (rd_ack),
    .ddr3_rd_data  (ddr3_rd_data),
    .ddr3_rd_valid (ddr3_rd_valid),
    .rd_data       (rd_data),
    .rd_valid      (rd_valid),
    .rd_outstanding(rd_outstanding),
    .rd_full       (rd_full_s),
    .err_underflow (err_underflow)
  );

endmodule

// File: tb/tb_ddr3_rw_arbiter.sv
// -----------------------------------------------------------------------------
// tb_ddr3_rw_arbiter
// Scoreboard bench: requester tasks push expected commands and read returns
// into queues; a monitor pops and compares whenever DDR3 accepts a command or
// rd_valid is presented. A small DDR3 model acks commands after a programmable
// delay and returns read data on demand.
// -----------------------------------------------------------------------------
module tb_ddr3_rw_arbiter;

  localparam int ADDR_W = 25;
  localparam int DATA_W = 256;
  localparam int CNT_W  = 3;

  logic              sys_clk = 1'b0;
  logic              sys_nrst = 1'b0;
  logic              wr_req = 1'b0;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [DATA_W-1:0] wr_data = '0;
  logic              wr_ack;
  logic              rd_req = 1'b0;
  logic [ADDR_W-1:0] rd_addr = '0;
  logic              rd_ack;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              ddr3_wd_req;
  logic [ADDR_W-1:0] ddr3_wd_addr;
  logic [DATA_W-1:0] ddr3_wd_data;
  logic              ddr3_wd_ack = 1'b0;
  logic              ddr3_rd_req;
  logic [ADDR_W-1:0] ddr3_rd_addr;
  logic              ddr3_rd_ack = 1'b0;
  logic [DATA_W-1:0] ddr3_rd_data = '0;
  logic              ddr3_rd_valid = 1'b0;
  logic [CNT_W-1:0]  rd_outstanding;
  logic              err_underflow;

  ddr3_rw_arbiter dut (
    .sys_clk       (sys_clk),
    .sys_nrst      (sys_nrst),
    .wr_req        (wr_req),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .wr_ack        (wr_ack),
    .rd_req        (rd_req),
    .rd_addr       (rd_addr),
    .rd_ack        (rd_ack),
    .rd_data       (rd_data),
    .rd_valid      (rd_valid),
    .ddr3_wd_req   (ddr3_wd_req),
    .ddr3_wd_addr  (ddr3_wd_addr),
    .ddr3_wd_data  (ddr3_wd_data),
    .ddr3_wd_ack   (ddr3_wd_ack),
    .ddr3_rd_req   (ddr3_rd_req),
    .ddr3_rd_addr  (ddr3_rd_addr),
    .ddr3_rd_ack   (ddr3_rd_ack),
    .ddr3_rd_data  (ddr3_rd_data),
    .ddr3_rd_valid (ddr3_rd_valid),
    .rd_outstanding(rd_outstanding),
    .err_underflow (err_underflow)
  );

  always #5 sys_clk = ~sys_clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [DATA_W-1:0] mk_data(input logic [ADDR_W-1:0] a);
    return {8{{7'd0, a} ^ 32'hC3C3_0000}};
  endfunction

  logic [DATA_W-1:0] uf_data = {8{32'hDEAD_BEEF}};

  // Scoreboard queues (pushed by stimulus, popped by the monitor)
  logic [ADDR_W-1:0] wr_exp_a_q[$];
  logic [DATA_W-1:0] wr_exp_d_q[$];
  logic [ADDR_W-1:0] rd_exp_a_q[$];
  logic [DATA_W-1:0] ret_exp_q[$];
  string             glog = "";

  // DDR3 model controls (written only by stimulus)
  int wd_delay   = 0;
  int rd_delay   = 0;
  int ret_issued = 0;
  bit vwa        = 1'b0;   // return only together with a read ack

  // DDR3 model state (written only by the model)
  int                wd_cyc   = 0;
  int                rd_cyc   = 0;
  int                ret_done = 0;
  logic [ADDR_W-1:0] pend_q[$];

  always @(posedge sys_clk) begin
    #1;
    if (ddr3_wd_req) begin
      wd_cyc++;
      ddr3_wd_ack = (wd_cyc == wd_delay + 1);
    end else begin
      wd_cyc = 0;
      ddr3_wd_ack = 1'b0;
    end
    if (ddr3_rd_req) begin
      rd_cyc++;
      ddr3_rd_ack = (rd_cyc == rd_delay + 1);
      if (ddr3_rd_ack) pend_q.push_back(ddr3_rd_addr);
    end else begin
      rd_cyc = 0;
      ddr3_rd_ack = 1'b0;
    end
    if ((ret_done < ret_issued) && (!vwa || ddr3_rd_ack)) begin
      ddr3_rd_valid = 1'b1;
      ddr3_rd_data  = (pend_q.size() != 0) ? mk_data(pend_q.pop_front()) : uf_data;
      ret_done++;
    end else begin
      ddr3_rd_valid = 1'b0;
    end
  end

  // Monitor: compares whatever the DUT presents against the queues.
  always @(negedge sys_clk) begin
    if (sys_nrst) begin
      if (ddr3_wd_req || ddr3_rd_req)
        check("one_req", {255'd0, ddr3_wd_req & ddr3_rd_req}, 256'd0);
      if (ddr3_wd_req && ddr3_wd_ack) begin
        check("wr_ack_pulse", {255'd0, wr_ack}, 256'd1);
        check("wr_exp_avail", {255'd0, wr_exp_a_q.size() != 0}, 256'd1);
        if (wr_exp_a_q.size() != 0) begin
          check("wd_addr", {231'd0, ddr3_wd_addr}, {231'd0, wr_exp_a_q.pop_front()});
          check("wd_data", ddr3_wd_data, wr_exp_d_q.pop_front());
        end
        glog = {glog, "W"};
      end else if (wr_ack) begin
        check("wr_ack_spurious", {255'd0, wr_ack}, 256'd0);
      end
      if (ddr3_rd_req && ddr3_rd_ack) begin
        check("rd_ack_pulse", {255'd0, rd_ack}, 256'd1);
        check("rd_exp_avail", {255'd0, rd_exp_a_q.size() != 0}, 256'd1);
        if (rd_exp_a_q.size() != 0)
          check("rd_addr", {231'd0, ddr3_rd_addr}, {231'd0, rd_exp_a_q.pop_front()});
        glog = {glog, "R"};
      end else if (rd_ack) begin
        check("rd_ack_spurious", {255'd0, rd_ack}, 256'd0);
      end
      if (rd_valid) begin
        check("ret_exp_avail", {255'd0, ret_exp_q.size() != 0}, 256'd1);
        if (ret_exp_q.size() != 0) check("rd_data", rd_data, ret_exp_q.pop_front());
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge sys_clk);
    #2;
  endtask

  // Write requester: hold wr_req until wr_ack, drop after the accepting edge.
  task automatic issue_wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    bit got = 1'b0;
    wr_addr = a;
    wr_data = d;
    wr_req  = 1'b1;
    wr_exp_a_q.push_back(a);
    wr_exp_d_q.push_back(d);
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge sys_clk);
      if (wr_ack) got = 1'b1;
    end
    check("wr_timeout", {255'd0, got}, 256'd1);
    @(posedge sys_clk);
    #2;
    wr_req = 1'b0;
  endtask

  // Read requester: same handshake; expected return pushed at issue.
  task automatic issue_rd(input logic [ADDR_W-1:0] a);
    bit got = 1'b0;
    rd_addr = a;
    rd_req  = 1'b1;
    rd_exp_a_q.push_back(a);
    ret_exp_q.push_back(mk_data(a));
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge sys_clk);
      if (rd_ack) got = 1'b1;
    end
    check("rd_timeout", {255'd0, got}, 256'd1);
    @(posedge sys_clk);
    #2;
    rd_req = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_wd_req"}, {255'd0, ddr3_wd_req}, 256'd0);
    check({tag, "_rd_req"}, {255'd0, ddr3_rd_req}, 256'd0);
    check({tag, "_wd_addr"}, {231'd0, ddr3_wd_addr}, 256'd0);
    check({tag, "_wd_data"}, ddr3_wd_data, 256'd0);
    check({tag, "_wr_ack"}, {255'd0, wr_ack}, 256'd0);
    check({tag, "_rd_valid"}, {255'd0, rd_valid}, 256'd0);
    check({tag, "_outst"}, {253'd0, rd_outstanding}, 256'd0);
    check({tag, "_err"}, {255'd0, err_underflow}, 256'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int    g0;
    int    k;
    string exp_pat;

    // ---- reset state ----
    #12;
    check_all_zero("rst");
    @(posedge sys_clk);
    #2;
    sys_nrst = 1'b1;
    idle(2);

    // ---- single write, ack 3 cycles after req ----
    g0 = glog.len();
    wd_delay = 3;
    k = -1;
    fork
      issue_wr(25'h0000010, {32{8'hA5}});
      begin
        for (int i = 0; i < 20 && k < 0; i++) begin
          @(negedge sys_clk);
          if (i == 0) check("wd_req_lat0", {255'd0, ddr3_wd_req}, 256'd0);
          if (i == 1) check("wd_req_lat1", {255'd0, ddr3_wd_req}, 256'd1);
          if (wr_ack) k = i;
        end
        check("wr_ack_cycle", 256'(k), 256'd4);
      end
    join
    idle(4);
    check("one_cmd", 256'(glog.len() - g0), 256'd1);
    check("wd_req_low", {255'd0, ddr3_wd_req}, 256'd0);

    // ---- both requesters continuous: 8 writes then 1 read ----
    wd_delay = 0;
    rd_delay = 0;
    g0 = glog.len();
    fork
      for (int i = 0; i < 16; i++) issue_wr(25'h100 + 25'(i), ~mk_data(25'h100 + 25'(i)));
      for (int i = 0; i < 2; i++) issue_rd(25'h200 + 25'(i));
    join
    idle(3);
    exp_pat = "WWWWWWWWRWWWWWWWWR";
    check("burst_len", 256'(glog.len() - g0), 256'd18);
    for (int i = 0; i < 18; i++)
      if (g0 + i < glog.len())
        check($sformatf("grant_seq%0d", i), {248'd0, glog[g0+i]}, {248'd0, exp_pat[i]});
    check("outst_2", {253'd0, rd_outstanding}, 256'd2);

    // ---- read ack and read return in the same cycle ----
    vwa = 1'b1;
    ret_issued++;
    fork
      issue_rd(25'h300);
      begin
        k = -1;
        for (int i = 0; i < 50 && k < 0; i++) begin
          @(negedge sys_clk);
          if (ddr3_rd_valid) k = i;
        end
        check("same_cyc_seen", {255'd0, k >= 0}, 256'd1);
        @(negedge sys_clk);
        check("rv_latency", {255'd0, rd_valid}, 256'd1);
        check("outst_same", {253'd0, rd_outstanding}, 256'd2);
      end
    join
    vwa = 1'b0;
    ret_issued += 2;
    idle(6);
    check("outst_drain", {253'd0, rd_outstanding}, 256'd0);

    // ---- read throttle at 4 outstanding ----
    g0 = glog.len();
    fork
      for (int i = 0; i < 5; i++) issue_rd(25'h400 + 25'(i));
      begin
        repeat (30) @(negedge sys_clk);
        check("thr_outst", {253'd0, rd_outstanding}, 256'd4);
        check("thr_grants", 256'(glog.len() - g0), 256'd4);
        @(posedge sys_clk);
        #2;
        ret_issued++;
      end
    join
    idle(3);
    check("thr_fifth", 256'(glog.len() - g0), 256'd5);
    check("thr_outst2", {253'd0, rd_outstanding}, 256'd4);
    ret_issued += 4;
    idle(8);
    check("thr_drain", {253'd0, rd_outstanding}, 256'd0);
    check("err_clean", {255'd0, err_underflow}, 256'd0);

    // ---- underflow: return with nothing in flight ----
    ret_exp_q.push_back(uf_data);
    ret_issued++;
    idle(4);
    check("uf_outst", {253'd0, rd_outstanding}, 256'd0);
    check("uf_err", {255'd0, err_underflow}, 256'd1);
    issue_wr(25'h0055555, mk_data(25'h0055555));
    idle(3);
    check("uf_sticky", {255'd0, err_underflow}, 256'd1);

    // ---- reset during WR_GRANT before ack, then re-grant ----
    wd_delay = 5;
    g0 = glog.len();
    fork
      issue_wr(25'h0ABCDEF, ~mk_data(25'h0ABCDEF));
      begin
        repeat (2) @(negedge sys_clk);
        check("pre_rst_wd_req", {255'd0, ddr3_wd_req}, 256'd1);
        #1 sys_nrst = 1'b0;
        #1 check_all_zero("midrst");
        @(posedge sys_clk);
        #3 sys_nrst = 1'b1;
      end
    join
    idle(3);
    check("regrant_once", 256'(glog.len() - g0), 256'd1);
    check("regrant_q_empty", 256'(wr_exp_a_q.size()), 256'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ddr3_rw_arbiter.md
Name: ddr3_rw_arbiter

Overview:
Shares the single DDR3 user command port between two requesters.
- The frame writer (FIFO to DDR3) issues write commands.
- The readback engine (DDR3 to PCIe host) issues read commands.
- Grants one command at a time, bounds write starvation of reads with a burst limit, and throttles reads by the number outstanding.
- Sits between the writer/readback engines and the DDR3 controller wrapper, in the sys_clk domain.

Parameters:
ADDR_W, 25, DDR3 word address width (256-bit words)
DATA_W, 256, data width
WR_BURST_MAX, 8, max consecutive write grants while a read is pending
RD_OUTSTANDING_MAX, 4, max read commands acked but not yet returned
CNT_W, 3, width of the outstanding counter; must hold RD_OUTSTANDING_MAX

Ports:
sys_clk  in  1  system clock
sys_nrst  in  1  reset, asynchronous, active-low
wr_req  in  1  write request, level, held until wr_ack
wr_addr  in  ADDR_W  write address, stable while wr_req
wr_data  in  DATA_W  write data, stable while wr_req
wr_ack  out  1  write accepted (combinational pulse)
rd_req  in  1  read request, level, held until rd_ack
rd_addr  in  ADDR_W  read address, stable while rd_req
rd_ack  out  1  read accepted (combinational pulse)
rd_data  out  DATA_W  returned read data (registered)
rd_valid  out  1  rd_data valid (registered)
ddr3_wd_req  out  1  DDR3 write command request
ddr3_wd_addr  out  ADDR_W  DDR3 write address
ddr3_wd_data  out  DATA_W  DDR3 write data
ddr3_wd_ack  in  1  DDR3 write command acknowledge
ddr3_rd_req  out  1  DDR3 read command request
ddr3_rd_addr  out  ADDR_W  DDR3 read address
ddr3_rd_ack  in  1  DDR3 read command acknowledge
ddr3_rd_data  in  DATA_W  DDR3 read data
ddr3_rd_valid  in  1  DDR3 read data valid
rd_outstanding  out  CNT_W  reads in flight
err_underflow  out  1  sticky: ddr3_rd_valid seen with zero outstanding

Behaviour:
- Reset (async, sys_nrst low): all outputs 0; state IDLE; write-burst count 0; outstanding count 0; err_underflow cleared.
- States: IDLE, WR_GRANT, RD_GRANT.
- IDLE arbitration, evaluated each cycle:
  - rd_ok = rd_req & (rd_outstanding < RD_OUTSTANDING_MAX).
  - wr_req only: go to WR_GRANT.
  - rd_ok only: go to RD_GRANT.
  - Both: go to RD_GRANT if burst count == WR_BURST_MAX, else WR_GRANT.
  - Neither: stay in IDLE.
- On the grant transition:
  - Latch address (and data for writes) into ddr3_*_addr / ddr3_wd_data.
  - Register ddr3_*_req = 1, so req is visible the cycle after the decision.
- WR_GRANT: hold ddr3_wd_req and latched address/data until ddr3_wd_ack.
  - wr_ack = ddr3_wd_ack & (state == WR_GRANT), combinational.
  - On that edge: ddr3_wd_req = 0; state goes to IDLE.
  - Burst count increments, saturating at WR_BURST_MAX, but only if rd_req is high at that edge; otherwise it clears.
- RD_GRANT: same handshake on ddr3_rd_req / ddr3_rd_ack / rd_ack.
  - On ack: burst count clears; state goes to IDLE.
- Minimum spacing: at least one IDLE cycle between commands. This guarantees a requester has dropped its req after ack before it is re-sampled.
- Only one of ddr3_wd_req / ddr3_rd_req is high at any time; never both.
- Outstanding counter:
  - +1 on ddr3_rd_ack in RD_GRANT; −1 on ddr3_rd_valid.
  - Both in the same cycle: unchanged.
  - ddr3_rd_valid at 0: counter stays 0, err_underflow set to 1, held until reset.
- Return path: rd_data / rd_valid are ddr3_rd_data / ddr3_rd_valid registered with 1 cycle latency, in order, no backpressure.
- Read throttle: when rd_outstanding == RD_OUTSTANDING_MAX, reads are not granted; writes proceed.
- Requests dropped before ack: not supported. The arbiter keeps driving the DDR3 req regardless.
- Reset mid-grant: DDR3 req drops immediately; in-flight read data after reset is not counted.

Decomposition:
- Package ddr3_pkg holds:
  - ADDR_W and DATA_W defaults.
  - typedef enum arb_state_t {IDLE, WR_GRANT, RD_GRANT}.
  - typedef ddr3_addr_t logic [ADDR_W-1:0].
- Sub-module ddr3_rd_tracker holds the outstanding counter, the full flag (count == RD_OUTSTANDING_MAX), err_underflow and the rd_data/rd_valid register stage.

Test Plan:
- Reset, then wr_req with addr 0x0000010 and data 0xA5…A5; ddr3_wd_ack 3 cycles after req → ddr3_wd_req rises 1 cycle after wr_req; addr/data match; wr_ack pulses in the ack cycle; one command only.
- wr_req and rd_req both held continuously, acks immediate, WR_BURST_MAX=8 → grant pattern 8 writes, 1 read, repeating; never both DDR3 reqs high.
- rd_req held, ddr3_rd_ack immediate, no ddr3_rd_valid → exactly 4 reads granted; rd_outstanding=4; a fifth read is granted only after one ddr3_rd_valid.
- ddr3_rd_ack and ddr3_rd_valid in the same cycle with outstanding=2 → stays 2; rd_valid rises next cycle with matching data.
- ddr3_rd_valid with outstanding=0 → counter stays 0; err_underflow=1 until sys_nrst.
- sys_nrst low during WR_GRANT before ack → all outputs 0 asynchronously; after release, held wr_req is re-granted from IDLE.
